// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the pixel-position type for the
// VGA pixel-clock domain.
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  localparam int VGA_CNT_W = 10;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] col;
    logic [VGA_CNT_W-1:0] row;
  } vga_pos_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to re-time the decoded sync and
// video-enable bits onto the pixel-data timeline.
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock timing generator: raw position counters, a stage-0 decode
// register for early pixel lookup, and delayed syncs aligned with pixel data.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIPE_DLY  = 2,
  parameter int CNT_W     = VGA_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_pix_col,
  output logic [CNT_W-1:0] o_pix_row,
  output logic             o_pix_req,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_vga_h_sync,
  output logic             o_vga_v_sync,
  output logic             o_vga_vid_en
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP_C   = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_DISP_C   = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  localparam logic [2:0] DLY_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             req_d;
  logic             hs_d;
  logic             vs_d;

  logic [CNT_W-1:0] col_p0;
  logic [CNT_W-1:0] row_p0;
  logic             req_p0;
  logic             hs_p0;
  logic             vs_p0;
  logic             line_p0;
  logic             frame_p0;

  logic [2:0]       dly_out;

  // Decode of the current counter position
  always_comb begin
    req_d = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
    hs_d  = ((h_cnt >= HS_START_C) && (h_cnt < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = ((v_cnt >= VS_START_C) && (v_cnt < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
  end

  // Counters and stage 0
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      col_p0   <= '0;
      row_p0   <= '0;
      req_p0   <= 1'b0;
      hs_p0    <= ~SYNC_POL;
      vs_p0    <= ~SYNC_POL;
      line_p0  <= 1'b0;
      frame_p0 <= 1'b0;
    end else if (i_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      col_p0   <= h_cnt;
      row_p0   <= v_cnt;
      req_p0   <= req_d;
      hs_p0    <= hs_d;
      vs_p0    <= vs_d;
      line_p0  <= (h_cnt == '0);
      frame_p0 <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // Pulses must not stretch across a stall
      line_p0  <= 1'b0;
      frame_p0 <= 1'b0;
    end
  end

  // Stage 0 to pins: PIPE_DLY enabled cycles
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (DLY_RST)
  ) u_sync_dly (
    .clk   (i_clk),
    .rst_n (i_rst),
    .en    (i_en),
    .din   ({hs_p0, vs_p0, req_p0}),
    .dout  (dly_out)
  );

  assign o_pix_col     = col_p0;
  assign o_pix_row     = row_p0;
  assign o_pix_req     = req_p0;
  assign o_line_start  = line_p0;
  assign o_frame_start = frame_p0;
  assign o_vga_h_sync  = dly_out[2];
  assign o_vga_v_sync  = dly_out[1];
  assign o_vga_vid_en  = dly_out[0];

endmodule
